virtio_common_cfg: RTL and testbench
====================================

# virtio_common_cfg

Parametrised virtio 1.x PCI common-configuration register file on a Xilinx BRAM_PORTA-style slave port (BRAM controller master, read latency 1).
- Per-queue state (size, MSI-X vector, enable, ring addresses) is held for `NUM_QUEUES` queues and selected by `queue_select`.
- Adds device-reset sequencing, a config-generation counter and a side read port used by the virtqueue DMA engine.
- Sits between the AXI BRAM controller on the BAR and the virtqueue engines.

## Interface
Parameters:
- `NUM_QUEUES`, 2: number of virtqueues, ≥1. `QW = max(1, clog2(NUM_QUEUES))`.
- `QUEUE_SIZE_MAX`, 256: power of two; per-queue reset value and upper bound of `queue_size`.
- `DEVICE_FEATURES`, 64'h0000_0001_0000_0000: read-only device feature bits. Bit 32 is VERSION_1.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: port enable.
- `we` in 4: byte write enables. A write is `en && we != 0`.
- `addr` in 32: byte address. Decoded from `addr[11:0]`; `addr[31:12]` is ignored.
- `din` in 32: write data.
- `dout` out 32: read data, registered.
- `driver_features` out 64: current driver feature bits.
- `device_status` out 8: current device status.
- `queue_enable` out `NUM_QUEUES`: per-queue enable vector.
- `cfg_change` in 1: single-cycle pulse that bumps the config generation.
- `reset_busy` out 1: per-queue clear sweep in progress.
- `reset_done` out 1: one-cycle pulse when the sweep ends.
- `q_idx` in `QW`: side-port queue index.
- `q_size` out 16: side-port read of the indexed queue. Combinational.
- `q_desc`, `q_driver`, `q_device` out 64 each: side-port reads of the indexed queue. Combinational.

## Operation
Register map (byte offsets; little-endian lanes):
- 0x00 device_feature_select (32). Register name is the select; the bank-select function is implemented only through 0x04.
- 0x04 device_feature (RO). Returns `DEVICE_FEATURES[32*sel +: 32]` for sel 0/1, else 0.
- 0x08 driver_feature_select (32).
- 0x0C driver_feature. Writes `driver_features` word sel 0/1; other sel values are ignored.
- 0x10 msix_config [15:0]; num_queues [31:16] (RO = `NUM_QUEUES`).
- 0x14 device_status [7:0]; config_generation [15:8] (RO); queue_select [31:16].
- 0x18 queue_size [15:0]; queue_msix_vector [31:16].
- 0x1C queue_enable [15:0]; queue_notify_off [31:16] (RO = queue_select).
- 0x20/0x24 queue_desc lo/hi.
- 0x28/0x2C queue_driver lo/hi.
- 0x30/0x34 queue_device lo/hi.
- Offsets 0x38–0xFFF read 0; writes are ignored.

Write rules:
- Byte lanes are merged per field; a field changes only in its enabled lanes.
- Writes to RO fields are ignored.
- Per-queue fields (0x18–0x37) address entry `queue_select`.
- If `queue_select >= NUM_QUEUES`: per-queue reads return 0 and per-queue writes are ignored.
- `queue_size` write with a merged value that is 0, not a power of two, or `> QUEUE_SIZE_MAX` is ignored.
- While `queue_enable[qs] = 1`, writes to that queue's size, vector and address fields are ignored.
- `queue_enable`: writing bit0 = 1 sets the bit; writing 0 is ignored. Only a device reset clears it.

Device reset: writing device_status lane 0 with 0x00 (or `rst`) does the following.
- Cleared immediately: both feature selects, `driver_features`, msix_config = 0xFFFF, queue_select.
- FSM moves IDLE → SWEEP with idx = 0.
- SWEEP clears entry idx each cycle: size = `QUEUE_SIZE_MAX`, vector = 0xFFFF, enable = 0, addresses = 0. Per-queue state must be implementable in LUTRAM.
- After idx = `NUM_QUEUES-1`: `device_status` ← 0x00, `reset_done` = 1 for one cycle, FSM → IDLE.
- During SWEEP: all bus writes are ignored; reads are served normally, and device_status returns its pre-reset value.
- A nonzero device_status write is stored as-is.

Config generation and side port:
- config_generation increments on `cfg_change`, wraps 0xFF → 0x00, and is cleared by `rst` only.
- Side port reads the entry at `q_idx`. For `q_idx >= NUM_QUEUES` all outputs are 0.

## Timing
- Read: `dout` is updated at the edge where `en = 1` with the data at `addr`. It holds otherwise.
- Read during a write to the same address returns the pre-write value (read-first).
- Writes take effect at the edge where they are sampled. Outputs and the side port reflect them from the next cycle.
- `rst` high at an edge produces:
  - `dout` = 0, `device_status` = 0, `driver_features` = 0, `queue_enable` = 0, `reset_done` = 0, `reset_busy` = 1, config_generation = 0.
  - The sweep then starts on the first cycle with `rst` low.
  - `rst` mid-sweep restarts the sweep at idx 0.
- `reset_busy` is high for exactly `NUM_QUEUES` cycles after the triggering edge. `reset_done` is asserted on the last of them.
- `cfg_change` coincident with any bus access: both take effect.

## Test plan
- After rst, `NUM_QUEUES=4`: `reset_busy` high for 4 cycles, `reset_done` pulse; read 0x10 → 0x0004FFFF; read 0x18 → 0xFFFF0100.
- Write 0x16 ← 2 (`we`=1100), write 0x18 ← 0x40 (`we`=0011), write 0x1C ← 1 (`we`=0011). Then:
  - read 0x18 → 0xFFFF0040; read 0x1C → 0x00020001; `queue_enable` = 4'b0100.
  - `q_idx`=2 gives `q_size` = 0x40.
- With queue 2 enabled: write 0x18 ← 0x20 → ignored. Select queue 3 and write size 0x30 or 0x200 → both ignored, read 0x100.
- Write 0x08 ← 1, 0x0C ← 0x1 → `driver_features` = 64'h1_0000_0000. Write 0x00 ← 1 → read 0x04 → 0x00000001.
- Write device_status ← 0x0F, then ← 0x00. Reads during the sweep return 0x0F in byte 0, and a write attempted during the sweep is ignored. After `reset_done`: status 0, `queue_enable` = 0, `driver_features` = 0.
- 256 `cfg_change` pulses → config_generation wraps to 0x00. Read 0x40 → 0; read with `addr` = 0x1000_0014 aliases 0x14.

Source files
------------

// File: rtl/virtio_common_cfg_if.sv
// virtio_common_cfg_if
//   BRAM_PORTA-style slave bus between an AXI BRAM controller (master) and
//   the virtio common-configuration register file (slave). Read latency 1.
//   en    : port enable; a read happens on every enabled edge
//   we    : byte write enables; a write is en && we != 0
//   addr  : byte address
//   din   : write data
//   dout  : registered read data
interface virtio_common_cfg_if;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;

    modport master (output en, output we, output addr, output din, input dout);
    modport slave  (input en, input we, input addr, input din, output dout);
endinterface

// File: rtl/virtio_common_cfg.sv
// virtio_common_cfg
//   virtio 1.x PCI common-configuration register file with per-queue state
//   for NUM_QUEUES virtqueues, device-reset sweep, config generation counter
//   and a combinational side read port for the virtqueue DMA engine.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   bus               : BRAM-style slave port (en/we/addr/din/dout)
//   driver_features   : accepted driver feature bits
//   device_status     : current device status byte
//   queue_enable      : per-queue enable vector
//   cfg_change        : pulse that bumps config_generation
//   reset_busy        : per-queue clear sweep in progress
//   reset_done        : one-cycle pulse on the last sweep cycle
//   q_idx             : side-port queue index
//   q_size/q_desc/q_driver/q_device : side-port reads of entry q_idx
module virtio_common_cfg #(
    parameter int unsigned NUM_QUEUES      = 2,
    parameter int unsigned QUEUE_SIZE_MAX  = 256,
    parameter logic [63:0] DEVICE_FEATURES = 64'h0000_0001_0000_0000,
    localparam int unsigned QW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    virtio_common_cfg_if.slave    bus,
    output logic [63:0]           driver_features,
    output logic [7:0]            device_status,
    output logic [NUM_QUEUES-1:0] queue_enable,
    input  logic                  cfg_change,
    output logic                  reset_busy,
    output logic                  reset_done,
    input  logic [QW-1:0]         q_idx,
    output logic [15:0]           q_size,
    output logic [63:0]           q_desc,
    output logic [63:0]           q_driver,
    output logic [63:0]           q_device
);
    localparam logic [15:0]   NQ16   = 16'(NUM_QUEUES);
    localparam logic [QW:0]   NQW    = (QW + 1)'(NUM_QUEUES);
    localparam logic [QW-1:0] LAST   = QW'(NUM_QUEUES - 1);
    localparam logic [15:0]   QMAX16 = 16'(QUEUE_SIZE_MAX);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t      state;
    logic [QW-1:0] idx;
    logic [31:0] dev_feat_sel;
    logic [31:0] drv_feat_sel;
    logic [15:0] msix_config;
    logic [15:0] queue_select;
    logic [7:0]  cfg_gen;

    // Per-queue storage: one write port and asynchronous reads, so it maps to LUTRAM.
    logic [15:0] size_mem [NUM_QUEUES];
    logic [15:0] vec_mem  [NUM_QUEUES];
    logic [63:0] desc_mem [NUM_QUEUES];
    logic [63:0] drv_mem  [NUM_QUEUES];
    logic [63:0] dev_mem  [NUM_QUEUES];

    logic [9:0]    word;
    logic [QW-1:0] qs;
    logic [QW-1:0] mem_a;
    logic          qs_ok, q_ok, wr, dev_rst_wr, q_open, sweeping;
    logic [31:0]   rd_data, merged;
    logic          unused_addr;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return r;
    endfunction

    function automatic logic size_ok(input logic [15:0] v);
        return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0) && ({16'd0, v} <= QUEUE_SIZE_MAX);
    endfunction

    function automatic logic [63:0] put_half(input logic [63:0] old_v,
                                             input logic [31:0] w, input logic hi);
        return hi ? {w, old_v[31:0]} : {old_v[63:32], w};
    endfunction

    assign word        = bus.addr[11:2];
    assign unused_addr = ^{bus.addr[31:12], bus.addr[1:0]};
    assign qs          = queue_select[QW-1:0];
    assign qs_ok       = queue_select < NQ16;
    assign sweeping    = (state == SWEEP) && !rst;
    assign wr          = bus.en && (bus.we != 4'd0) && (state == IDLE) && !rst;
    assign dev_rst_wr  = wr && (word == 10'h005) && bus.we[0] && (bus.din[7:0] == 8'h00);
    assign q_open      = wr && qs_ok && !queue_enable[qs];
    assign mem_a       = sweeping ? idx : qs;
    // Writes merge into the current read value of the word, so every field
    // keeps its old bytes in lanes that are not enabled.
    assign merged      = merge_lanes(rd_data, bus.din, bus.we);

    always_comb begin
        rd_data = '0;
        case (word)
            10'h000: rd_data = dev_feat_sel;
            10'h001: rd_data = (dev_feat_sel == 32'd0) ? DEVICE_FEATURES[31:0] :
                               (dev_feat_sel == 32'd1) ? DEVICE_FEATURES[63:32] : 32'd0;
            10'h002: rd_data = drv_feat_sel;
            10'h003: rd_data = (drv_feat_sel == 32'd0) ? driver_features[31:0] :
                               (drv_feat_sel == 32'd1) ? driver_features[63:32] : 32'd0;
            10'h004: rd_data = {NQ16, msix_config};
            10'h005: rd_data = {queue_select, cfg_gen, device_status};
            10'h006: if (qs_ok) rd_data = {vec_mem[qs], size_mem[qs]};
            10'h007: if (qs_ok) rd_data = {queue_select, 15'd0, queue_enable[qs]};
            10'h008: if (qs_ok) rd_data = desc_mem[qs][31:0];
            10'h009: if (qs_ok) rd_data = desc_mem[qs][63:32];
            10'h00A: if (qs_ok) rd_data = drv_mem[qs][31:0];
            10'h00B: if (qs_ok) rd_data = drv_mem[qs][63:32];
            10'h00C: if (qs_ok) rd_data = dev_mem[qs][31:0];
            10'h00D: if (qs_ok) rd_data = dev_mem[qs][63:32];
            default: rd_data = '0;
        endcase
    end

    // Control registers, read register and the reset sweep FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dout        <= '0;
            device_status   <= '0;
            driver_features <= '0;
            queue_enable    <= '0;
            reset_done      <= 1'b0;
            reset_busy      <= 1'b1;
            cfg_gen         <= '0;
            dev_feat_sel    <= '0;
            drv_feat_sel    <= '0;
            msix_config     <= 16'hFFFF;
            queue_select    <= '0;
            idx             <= '0;
            state           <= SWEEP;
        end else begin
            if (cfg_change) cfg_gen <= cfg_gen + 8'd1;
            if (bus.en) bus.dout <= rd_data;
            case (state)
                IDLE: begin
                    if (dev_rst_wr) begin
                        dev_feat_sel    <= '0;
                        drv_feat_sel    <= '0;
                        driver_features <= '0;
                        msix_config     <= 16'hFFFF;
                        queue_select    <= '0;
                        idx             <= '0;
                        reset_busy      <= 1'b1;
                        reset_done      <= (NUM_QUEUES == 1);
                        state           <= SWEEP;
                    end else if (wr) begin
                        case (word)
                            10'h000: dev_feat_sel <= merged;
                            10'h002: drv_feat_sel <= merged;
                            10'h003: begin
                                if (drv_feat_sel == 32'd0) driver_features[31:0]  <= merged;
                                if (drv_feat_sel == 32'd1) driver_features[63:32] <= merged;
                            end
                            10'h004: msix_config <= merged[15:0];
                            10'h005: begin
                                device_status <= merged[7:0];
                                queue_select  <= merged[31:16];
                            end
                            10'h007: if (qs_ok && bus.we[0] && bus.din[0]) queue_enable[qs] <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                SWEEP: begin
                    queue_enable[idx] <= 1'b0;
                    if (idx == LAST) begin
                        device_status <= 8'h00;
                        reset_busy    <= 1'b0;
                        reset_done    <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        idx        <= idx + QW'(1);
                        reset_done <= ((idx + QW'(1)) == LAST);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-queue storage: the sweep and bus writes never coincide.
    always_ff @(posedge clk) begin
        if (sweeping || (q_open && word == 10'h006 && size_ok(merged[15:0])))
            size_mem[mem_a] <= sweeping ? QMAX16 : merged[15:0];
        if (sweeping || (q_open && word == 10'h006))
            vec_mem[mem_a] <= sweeping ? 16'hFFFF : merged[31:16];
        if (sweeping || (q_open && (word == 10'h008 || word == 10'h009)))
            desc_mem[mem_a] <= sweeping ? 64'd0 : put_half(desc_mem[qs], merged, word[0]);
        if (sweeping || (q_open && (word == 10'h00A || word == 10'h00B)))
            drv_mem[mem_a] <= sweeping ? 64'd0 : put_half(drv_mem[qs], merged, word[0]);
        if (sweeping || (q_open && (word == 10'h00C || word == 10'h00D)))
            dev_mem[mem_a] <= sweeping ? 64'd0 : put_half(dev_mem[qs], merged, word[0]);
    end

    assign q_ok     = {1'b0, q_idx} < NQW;
    assign q_size   = q_ok ? size_mem[q_idx] : 16'd0;
    assign q_desc   = q_ok ? desc_mem[q_idx] : 64'd0;
    assign q_driver = q_ok ? drv_mem[q_idx]  : 64'd0;
    assign q_device = q_ok ? dev_mem[q_idx]  : 64'd0;
endmodule

// File: tb/tb_virtio_common_cfg.sv
// tb_virtio_common_cfg
//   Bench for virtio_common_cfg with NUM_QUEUES = 4. Reads push their
//   expected data into a scoreboard queue when driven and are popped and
//   compared one cycle later. Register traffic is table driven; reset
//   sweeps, config generation and read-first timing are hand sequences.
module tb_virtio_common_cfg;
    logic        clk;
    logic        rst;
    logic        cfg_change;
    logic [1:0]  q_idx;
    logic [63:0] driver_features;
    logic [7:0]  device_status;
    logic [3:0]  queue_enable;
    logic        reset_busy;
    logic        reset_done;
    logic [15:0] q_size;
    logic [63:0] q_desc, q_driver, q_device;

    virtio_common_cfg_if bus();

    virtio_common_cfg #(.NUM_QUEUES(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus.slave),
        .driver_features (driver_features),
        .device_status   (device_status),
        .queue_enable    (queue_enable),
        .cfg_change      (cfg_change),
        .reset_busy      (reset_busy),
        .reset_done      (reset_done),
        .q_idx           (q_idx),
        .q_size          (q_size),
        .q_desc          (q_desc),
        .q_driver        (q_driver),
        .q_device        (q_device)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] din;
        logic        chk;
        logic [31:0] exp;
        string       name;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   busy_cnt = 0;
    int   done_cnt = 0;
    int   done_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sample_ctl();
        if (reset_busy) busy_cnt++;
        if (reset_done) begin
            done_cnt++;
            if (!reset_busy) done_bad++;
        end
    endtask

    task automatic step(input logic en, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] din, input logic chk, input logic [31:0] exp,
                        input string name);
        exp_t e;
        @(negedge clk);
        sample_ctl();
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.name, {32'd0, bus.dout}, {32'd0, e.val});
        end
        bus.en   = en;
        bus.we   = we;
        bus.addr = addr;
        bus.din  = din;
        if (en && chk) exp_q.push_back('{name, exp});
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 32'd0, "");
    endtask

    task automatic wr(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] din);
        step(1'b1, we, addr, din, 1'b0, 32'd0, "");
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        step(1'b1, 4'd0, addr, 32'd0, 1'b1, exp, name);
    endtask

    task automatic add_w(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] din);
        tbl.push_back('{we, addr, din, 1'b0, 32'd0, ""});
    endtask

    task automatic add_r(input logic [31:0] addr, input logic [31:0] exp, input string name);
        tbl.push_back('{4'd0, addr, 32'd0, 1'b1, exp, name});
    endtask

    task automatic pulse_cfg();
        idle();
        cfg_change = 1'b1;
        idle();
        cfg_change = 1'b0;
    endtask

    task automatic wait_sweep(input string name);
        int guard;
        guard = 0;
        while (reset_busy && guard < 20) begin
            idle();
            guard++;
        end
        check({name, "_end"}, {63'd0, reset_busy}, 64'd0);
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'd4);
        check({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({name, "_done_outside_busy"}, 64'(done_bad), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_change = 1'b0; q_idx = 2'd0;
        bus.en = 1'b0; bus.we = 4'd0; bus.addr = 32'd0; bus.din = 32'd0;

        // Register traffic table, applied after the power-on sweep.
        add_r(32'h10, 32'h0004FFFF, "rst_num_q_msix");
        add_r(32'h18, 32'hFFFF0100, "rst_q0_size_vec");
        add_w(4'b1100, 32'h16, 32'h00020000);
        add_w(4'b0011, 32'h18, 32'h00000040);
        add_w(4'b0011, 32'h1C, 32'h00000001);
        add_r(32'h18, 32'hFFFF0040, "q2_size");
        add_r(32'h1C, 32'h00020001, "q2_en_notify");
        add_w(4'b0011, 32'h18, 32'h00000020);
        add_w(4'b1111, 32'h20, 32'hDEADBEEF);
        add_r(32'h18, 32'hFFFF0040, "q2_size_locked");
        add_r(32'h20, 32'h00000000, "q2_desc_locked");
        add_w(4'b1100, 32'h14, 32'h00030000);
        add_w(4'b0011, 32'h18, 32'h00000030);
        add_r(32'h18, 32'hFFFF0100, "q3_size_npow2");
        add_w(4'b0011, 32'h18, 32'h00000200);
        add_r(32'h18, 32'hFFFF0100, "q3_size_too_big");
        add_w(4'b0011, 32'h18, 32'h00000000);
        add_r(32'h18, 32'hFFFF0100, "q3_size_zero");
        add_w(4'b1100, 32'h18, 32'h00070000);
        add_r(32'h18, 32'h00070100, "q3_vec_lanes");
        add_w(4'b0011, 32'h18, 32'h00000010);
        add_r(32'h18, 32'h00070010, "q3_size_ok");
        add_w(4'b1111, 32'h24, 32'h12345678);
        add_w(4'b0001, 32'h20, 32'h000000AB);
        add_r(32'h20, 32'h000000AB, "q3_desc_lo");
        add_r(32'h24, 32'h12345678, "q3_desc_hi");
        add_w(4'b1111, 32'h30, 32'h55667788);
        add_r(32'h30, 32'h55667788, "q3_device_lo");
        add_w(4'b1100, 32'h14, 32'h00070000);
        add_r(32'h18, 32'h00000000, "qsel_oob_size");
        add_w(4'b0011, 32'h18, 32'h00000008);
        add_r(32'h1C, 32'h00000000, "qsel_oob_enable");
        add_w(4'b1100, 32'h14, 32'h00030000);
        add_r(32'h18, 32'h00070010, "q3_after_oob");
        add_w(4'b1111, 32'h08, 32'h00000001);
        add_w(4'b1111, 32'h0C, 32'h00000001);
        add_r(32'h0C, 32'h00000001, "drv_feat_hi");
        add_w(4'b1111, 32'h08, 32'h00000002);
        add_w(4'b1111, 32'h0C, 32'h0000FFFF);
        add_r(32'h0C, 32'h00000000, "drv_feat_sel2");
        add_w(4'b1111, 32'h08, 32'h00000000);
        add_r(32'h0C, 32'h00000000, "drv_feat_lo");
        add_r(32'h04, 32'h00000000, "dev_feat_lo");
        add_w(4'b1111, 32'h00, 32'h00000001);
        add_r(32'h04, 32'h00000001, "dev_feat_hi");
        add_w(4'b1111, 32'h00, 32'h00000002);
        add_r(32'h04, 32'h00000000, "dev_feat_sel2");
        add_r(32'h00, 32'h00000002, "dev_feat_sel_rd");
        add_w(4'b0001, 32'h10, 32'h00000012);
        add_r(32'h10, 32'h0004FF12, "msix_lane0");
        add_w(4'b1111, 32'h10, 32'hABCD1234);
        add_r(32'h10, 32'h00041234, "msix_numq_ro");
        add_r(32'h40, 32'h00000000, "hole_rd");
        add_w(4'b1111, 32'h40, 32'hFFFFFFFF);
        add_r(32'h40, 32'h00000000, "hole_after_wr");
        add_r(32'h1000_0014, 32'h00030000, "addr_alias");

        // Power-on reset and sweep.
        repeat (3) @(negedge clk);
        check("rst_dout", {32'd0, bus.dout}, 64'd0);
        check("rst_busy", {63'd0, reset_busy}, 64'd1);
        check("rst_done", {63'd0, reset_done}, 64'd0);
        check("rst_qen", {60'd0, queue_enable}, 64'd0);
        check("rst_status", {56'd0, device_status}, 64'd0);
        check("rst_drv_feat", driver_features, 64'd0);
        busy_cnt = 0; done_cnt = 0; done_bad = 0;
        sample_ctl();
        rst = 1'b0;
        wait_sweep("por");

        for (int i = 0; i < tbl.size(); i++)
            step(1'b1, tbl[i].we, tbl[i].addr, tbl[i].din, tbl[i].chk, tbl[i].exp, tbl[i].name);
        idle();

        check("drv_features_port", driver_features, 64'h0000_0001_0000_0000);
        check("qen_port", {60'd0, queue_enable}, 64'h4);
        q_idx = 2'd2; #1;
        check("side_q2_size", {48'd0, q_size}, 64'h40);
        q_idx = 2'd3; #1;
        check("side_q3_size", {48'd0, q_size}, 64'h10);
        check("side_q3_desc", q_desc, 64'h12345678_000000AB);
        check("side_q3_driver", q_driver, 64'd0);
        check("side_q3_device", q_device, 64'h0000_0000_5566_7788);

        // Read-first on a write to the same word, then dout holds while en is low.
        step(1'b1, 4'b1111, 32'h10, 32'h0000ABCD, 1'b1, 32'h00041234, "read_first");
        rd(32'h10, 32'h0004ABCD, "after_write");
        idle();
        idle();
        check("dout_hold", {32'd0, bus.dout}, 64'h0004ABCD);

        // Config generation: count, coincident bus write, wrap after 256.
        for (int i = 0; i < 5; i++) pulse_cfg();
        rd(32'h14, 32'h00030500, "cfg_gen_5");
        wr(4'b1100, 32'h14, 32'h00010000);
        cfg_change = 1'b1;
        idle();
        cfg_change = 1'b0;
        rd(32'h14, 32'h00010600, "cfg_gen_with_write");
        for (int i = 0; i < 250; i++) pulse_cfg();
        rd(32'h14, 32'h00010000, "cfg_gen_wrap");
        for (int i = 0; i < 3; i++) pulse_cfg();

        // Device reset through device_status.
        wr(4'b0001, 32'h14, 32'h0000000F);
        rd(32'h14, 32'h0001030F, "status_0f");
        idle();
        check("status_port_0f", {56'd0, device_status}, 64'h0F);
        busy_cnt = 0; done_cnt = 0; done_bad = 0;
        wr(4'b0001, 32'h14, 32'h00000000);
        rd(32'h14, 32'h0000030F, "sweep_status_rd");
        wr(4'b0011, 32'h10, 32'h00001234);
        wr(4'b1100, 32'h14, 32'h00020000);
        wait_sweep("devrst");
        check("devrst_status", {56'd0, device_status}, 64'd0);
        check("devrst_qen", {60'd0, queue_enable}, 64'd0);
        check("devrst_drv_feat", driver_features, 64'd0);
        rd(32'h14, 32'h00000300, "devrst_status_gen");
        rd(32'h10, 32'h0004FFFF, "devrst_msix");
        wr(4'b1100, 32'h14, 32'h00020000);
        rd(32'h18, 32'hFFFF0100, "devrst_q2_size");
        rd(32'h1C, 32'h00020000, "devrst_q2_enable");
        wr(4'b1100, 32'h14, 32'h00030000);
        rd(32'h20, 32'h00000000, "devrst_q3_desc");
        idle();
        q_idx = 2'd3; #1;
        check("devrst_side_q3_size", {48'd0, q_size}, 64'h100);
        check("devrst_side_q3_device", q_device, 64'd0);

        idle();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
